// File: rtl/mem_stage_pkg.sv
// Shared encodings, widths and state type for the memory-stage controller.
package mem_stage_pkg;
  localparam int WORD_W = 32;
  localparam int REG_W  = 5;

  localparam logic [1:0] MEM_NONE    = 2'b00;
  localparam logic [1:0] MEM_STORE   = 2'b01;
  localparam logic [1:0] MEM_LOAD    = 2'b10;
  localparam logic [1:0] MEM_ILLEGAL = 2'b11;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  function automatic logic is_access(input logic [1:0] cmd);
    return (cmd == MEM_STORE) || (cmd == MEM_LOAD);
  endfunction
endpackage

// File: rtl/mem_stage_ctrl_timer.sv
// Wait counter for an outstanding data-memory access; flags the cycle the
// count reaches MAX_WAIT.
module mem_wait_timer #(
  parameter int MAX_WAIT = 16
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr,
  input  logic en,
  output logic terminal
);
  logic [7:0] count_reg;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      count_reg <= '0;
    end else if (clr) begin
      count_reg <= '0;
    end else if (en) begin
      count_reg <= count_reg + 8'd1;
    end
  end

  // High during the enabled cycle whose increment brings the count to MAX_WAIT.
  assign terminal = en && (count_reg == 8'(MAX_WAIT - 1));
endmodule

// File: rtl/mem_stage_ctrl.sv
// MEM stage: performs loads/stores over a req/ack handshake, stalls the
// pipeline while the access is outstanding, and drives the MEM/WB register.
module mem_stage_ctrl
  import mem_stage_pkg::*;
#(
  parameter int MAX_WAIT = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [WORD_W-1:0] Memaddr_i,
  input  logic [WORD_W-1:0] Memdata_i,
  input  logic [1:0]        Mem_i,
  input  logic              WB_i,
  input  logic [REG_W-1:0]  rd_addr_i,
  input  logic [WORD_W-1:0] ALUres_i,
  output logic              stall_o,
  output logic              err_o,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [WORD_W-1:0] mem_addr_o,
  output logic [WORD_W-1:0] mem_wdata_o,
  input  logic              mem_ack_i,
  input  logic [WORD_W-1:0] mem_rdata_i,
  output logic              WB_o,
  output logic [REG_W-1:0]  rd_addr_o,
  output logic [WORD_W-1:0] wbdata_o
);
  state_t            state_reg;
  logic              is_load_reg;
  logic [WORD_W-1:0] rdata_reg;
  logic              aligned;
  logic              start_access;
  logic              timeout;

  assign aligned      = (Memaddr_i[1:0] == 2'b00);
  assign start_access = is_access(Mem_i) && aligned;

  // Gated by reset so an aborted access releases the pipeline immediately.
  assign stall_o = rst_i &&
                   (((state_reg == IDLE) && start_access) || (state_reg == BUSY));

  mem_wait_timer #(.MAX_WAIT(MAX_WAIT)) u_timer (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .clr      (state_reg != BUSY),
    .en       (state_reg == BUSY),
    .terminal (timeout)
  );

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_reg   <= IDLE;
      is_load_reg <= 1'b0;
      rdata_reg   <= '0;
      err_o       <= 1'b0;
      mem_req_o   <= 1'b0;
      mem_we_o    <= 1'b0;
      mem_addr_o  <= '0;
      mem_wdata_o <= '0;
      WB_o        <= 1'b0;
      rd_addr_o   <= '0;
      wbdata_o    <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (Mem_i == MEM_NONE) begin
            WB_o      <= WB_i;
            rd_addr_o <= rd_addr_i;
            wbdata_o  <= ALUres_i;
          end else begin
            WB_o      <= 1'b0;
            rd_addr_o <= '0;
            wbdata_o  <= '0;
            if (start_access) begin
              state_reg   <= BUSY;
              mem_req_o   <= 1'b1;
              mem_we_o    <= (Mem_i == MEM_STORE);
              mem_addr_o  <= Memaddr_i;
              mem_wdata_o <= Memdata_i;
              is_load_reg <= (Mem_i == MEM_LOAD);
            end else begin
              err_o <= 1'b1;
            end
          end
        end
        BUSY: begin
          WB_o      <= 1'b0;
          rd_addr_o <= '0;
          wbdata_o  <= '0;
          // An ack coinciding with the terminal count still completes cleanly.
          if (mem_ack_i) begin
            mem_req_o <= 1'b0;
            rdata_reg <= is_load_reg ? mem_rdata_i : '0;
            state_reg <= DONE;
          end else if (timeout) begin
            err_o     <= 1'b1;
            mem_req_o <= 1'b0;
            rdata_reg <= '0;
            state_reg <= DONE;
          end
        end
        DONE: begin
          WB_o      <= WB_i;
          rd_addr_o <= rd_addr_i;
          wbdata_o  <= is_load_reg ? rdata_reg : ALUres_i;
          state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end
endmodule
